// File: rtl/axis_trigger_gate_pkg.sv
// Shared types and constants for the trigger gate.
// Latency: n/a (types only).
// Backpressure: n/a.
package axis_trigger_gate_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLDOFF = 3'd1,
    PRIME   = 3'd2,
    WAIT    = 3'd3,
    FIRE    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int TSTAMP_WIDTH = 64;

  localparam logic SLOPE_FALL = 1'b0;
  localparam logic SLOPE_RISE = 1'b1;

endpackage

// File: rtl/axis_trigger_gate_cmp.sv
// Prime/fire level comparator for the selected slope.
// Latency: combinational.
// Backpressure: none; pure function of the current sample and the latched config.
// Ports: x (sample), level (signed), hyst (unsigned), slope -> prime, fire.
module axis_trigger_gate_cmp
  import axis_trigger_gate_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] level,
  input  logic [W-1:0] hyst,
  input  logic         slope,
  output logic         prime,
  output logic         fire
);

  // hyst is a full-width unsigned magnitude, so level-hyst can reach about
  // -1.5 * 2^W; two guard bits keep level +/- hyst exact for every input.
  localparam int EW = W + 2;

  logic signed [EW-1:0] xe, le, he, lo, hi;

  assign xe = {{2{x[W-1]}}, x};
  assign le = {{2{level[W-1]}}, level};
  assign he = {2'b00, hyst};
  assign lo = le - he;
  assign hi = le + he;

  always_comb begin
    prime = 1'b0;
    fire  = 1'b0;
    if (slope == SLOPE_RISE) begin
      prime = (xe < lo);
      fire  = (xe >= le);
    end else begin
      prime = (xe > hi);
      fire  = (xe <= le);
    end
  end

endmodule

// File: rtl/axis_trigger_gate.sv
// Trigger gate: after arm, holdoff then hysteresis-qualified crossing; forwards cfg_len samples from the trigger.
// Latency: 1 cycle from input accept to m_axis_tvalid (registered output slice).
// Backpressure: input always drained when gate closed; in FIRE a one-deep slice passes m_axis_tready upstream.
// Ports: aclk/aresetn (sync, active-low); arm + cfg_* (latched on arm); s_axis_* in; m_axis_* out;
//        trig (accept-cycle pulse), busy, done, trig_tstamp.
// Option: AXIS_TRIGGER_GATE_TSTAMP_EN adds a 64-bit accepted-sample counter latched into trig_tstamp.
module axis_trigger_gate
  import axis_trigger_gate_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        arm,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_level,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_hyst,
  input  logic                        cfg_slope,
  input  logic [CNTR_WIDTH-1:0]       cfg_holdoff,
  input  logic [CNTR_WIDTH-1:0]       cfg_len,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        trig,
  output logic                        busy,
  output logic                        done,
  output logic [TSTAMP_WIDTH-1:0]     trig_tstamp
);

  state_t                      state;
  logic [CNTR_WIDTH-1:0]       hcnt;
  logic [CNTR_WIDTH-1:0]       lcnt;   // samples still to load after the current one
  logic [AXIS_TDATA_WIDTH-1:0] level_q;
  logic [AXIS_TDATA_WIDTH-1:0] hyst_q;
  logic                        slope_q;
  logic [CNTR_WIDTH-1:0]       len_q;
  logic                        acc;
  logic                        prime_hit;
  logic                        fire_hit;

  axis_trigger_gate_cmp #(.W(AXIS_TDATA_WIDTH)) u_cmp (
    .x     (s_axis_tdata),
    .level (level_q),
    .hyst  (hyst_q),
    .slope (slope_q),
    .prime (prime_hit),
    .fire  (fire_hit)
  );

  // Nothing is accepted while reset is held. In FIRE the slice only takes a new
  // sample while more are owed (lcnt != 0) and the output register frees up.
  always_comb begin
    s_axis_tready = 1'b0;
    if (aresetn) begin
      if (state == FIRE)
        s_axis_tready = (lcnt != '0) && (!m_axis_tvalid || m_axis_tready);
      else
        s_axis_tready = 1'b1;
    end
  end

  assign acc  = s_axis_tvalid && s_axis_tready;
  assign trig = acc && (state == WAIT) && fire_hit;
  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      hcnt          <= '0;
      lcnt          <= '0;
      level_q       <= '0;
      hyst_q        <= '0;
      slope_q       <= 1'b0;
      len_q         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            level_q <= cfg_level;
            hyst_q  <= cfg_hyst;
            slope_q <= cfg_slope;
            len_q   <= cfg_len;
            hcnt    <= cfg_holdoff;
            state   <= (cfg_holdoff == '0) ? PRIME : HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (acc) begin
            hcnt <= hcnt - 1'b1;
            if (hcnt == CNTR_WIDTH'(1)) state <= PRIME;
          end
        end
        PRIME: begin
          // A sample that both primes and fires only primes.
          if (acc && prime_hit) state <= WAIT;
        end
        WAIT: begin
          if (acc && fire_hit) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            lcnt          <= (len_q == '0) ? '0 : len_q - 1'b1;
            state         <= FIRE;
          end
        end
        FIRE: begin
          if (acc) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            lcnt          <= lcnt - 1'b1;
          end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            // lcnt==0 means the register holds the final sample being drained now.
            if (lcnt == '0) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_TRIGGER_GATE_TSTAMP_EN
  logic [TSTAMP_WIDTH-1:0] smp_cnt;
  logic [TSTAMP_WIDTH-1:0] tstamp_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      smp_cnt  <= '0;
      tstamp_q <= '0;
    end else begin
      if (acc)  smp_cnt  <= smp_cnt + 1'b1;
      if (trig) tstamp_q <= smp_cnt;
    end
  end

  assign trig_tstamp = tstamp_q;
`else
  assign trig_tstamp = '0;
`endif

endmodule

// File: tb/tb_axis_trigger_gate.sv
module tb_axis_trigger_gate;
  import axis_trigger_gate_pkg::*;

  localparam int W = 16;
  localparam int C = 16;
`ifdef AXIS_TRIGGER_GATE_TSTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          arm = 1'b0;
  logic [W-1:0]  cfg_level = '0;
  logic [W-1:0]  cfg_hyst = '0;
  logic          cfg_slope = 1'b0;
  logic [C-1:0]  cfg_holdoff = '0;
  logic [C-1:0]  cfg_len = '0;
  logic [W-1:0]  s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          trig;
  logic          busy;
  logic          done;
  logic [63:0]   trig_tstamp;

  axis_trigger_gate #(.AXIS_TDATA_WIDTH(W), .CNTR_WIDTH(C)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .arm           (arm),
    .cfg_level     (cfg_level),
    .cfg_hyst      (cfg_hyst),
    .cfg_slope     (cfg_slope),
    .cfg_holdoff   (cfg_holdoff),
    .cfg_len       (cfg_len),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .trig          (trig),
    .busy          (busy),
    .done          (done),
    .trig_tstamp   (trig_tstamp)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [W-1:0] x;
    bit           fwd;   // expected on m_axis
    bit           trg;   // expected trig on its accept cycle
  } vec_t;

  vec_t         tv[$];
  logic [W-1:0] exp_q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  int           fwd_cnt = 0;
  int           acc_idx = 0;
  int           rdy_mode = 0;
  bit           bp_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready: 0 = always, 1 = pattern 1,0,0, 2 = stalled.
  initial begin
    int cyc;
    cyc = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      cyc++;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ((cyc % 3) == 0);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Scoreboard: every downstream handshake pops one expected sample.
  initial begin
    forever begin
      @(negedge aclk);
      if (s_tvalid && !s_tready) bp_seen = 1'b1;
      if (aresetn && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", m_tdata);
        end else begin
          check("fwd_data", 64'(m_tdata), 64'(exp_q.pop_front()));
          fwd_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic add(input int x, input bit fwd, input bit trg);
    vec_t v;
    v.x = W'(x);
    v.fwd = fwd;
    v.trg = trg;
    tv.push_back(v);
  endtask

  task automatic send(input vec_t v);
    int n;
    bit ok;
    s_tdata  = v.x;
    s_tvalid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge aclk);
      n++;
      if (s_tready) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: sample %0h not accepted, expected accept", v.x);
      s_tvalid = 1'b0;
      return;
    end
    check("trig", 64'(trig), 64'(v.trg));
    if (v.fwd) exp_q.push_back(v.x);
    @(posedge aclk);
    #1;
    if (v.trg) check("tstamp", trig_tstamp, TS_EN ? 64'(acc_idx) : 64'd0);
    acc_idx++;
    s_tvalid = 1'b0;
  endtask

  task automatic run_table();
    foreach (tv[i]) send(tv[i]);
    tv.delete();
  endtask

  task automatic do_arm(input int level, input int hyst, input logic slope,
                        input int holdoff, input int len);
    @(posedge aclk);
    #1;
    cfg_level   = W'(level);
    cfg_hyst    = W'(hyst);
    cfg_slope   = slope;
    cfg_holdoff = C'(holdoff);
    cfg_len     = C'(len);
    arm = 1'b1;
    @(posedge aclk);
    #1;
    arm = 1'b0;
    // Scramble config: the gate must use the values captured on arm.
    cfg_level   = W'($urandom);
    cfg_hyst    = W'($urandom);
    cfg_slope   = 1'($urandom);
    cfg_holdoff = C'($urandom);
    cfg_len     = C'($urandom);
  endtask

  task automatic wait_done(input int exp_fwd);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge aclk);
      n++;
    end
    @(negedge aclk);
    check("done", 64'(done), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("fwd_count", 64'(fwd_cnt), 64'(exp_fwd));
    fwd_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_trig", 64'(trig), 64'd0);
    check("rst_tstamp", trig_tstamp, 64'd0);
    exp_q.delete();
    acc_idx = 0;
    fwd_cnt = 0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    do_reset();

    // 1: rising ramp, fire on 0, forward 0..3.
    do_arm(0, 2, SLOPE_RISE, 0, 4);
    for (int x = -10; x <= 10; x++) add(x, (x >= 0 && x <= 3), (x == 0));
    run_table();
    wait_done(4);

    // 2: holdoff 15 swallows the only priming samples; gate stays in PRIME.
    do_arm(0, 2, SLOPE_RISE, 15, 4);
    for (int x = -10; x <= 10; x++) add(x, 1'b0, 1'b0);
    run_table();
    repeat (3) @(negedge aclk);
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_done", 64'(done), 64'd0);
    check("t2_m_tvalid", 64'(m_tvalid), 64'd0);
    do_reset();

    // 3: noise inside the band never primes; dip then +1 fires.
    do_arm(0, 2, SLOPE_RISE, 0, 2);
    for (int i = 0; i < 3; i++) begin
      add(-1, 1'b0, 1'b0);
      add(1, 1'b0, 1'b0);
    end
    add(-3, 1'b0, 1'b0);
    add(1, 1'b1, 1'b1);
    add(5, 1'b1, 1'b0);
    add(6, 1'b0, 1'b0);
    run_table();
    wait_done(2);

    // 4: len 8 under a 1,0,0 ready pattern.
    rdy_mode = 1;
    bp_seen  = 1'b0;
    do_arm(0, 2, SLOPE_RISE, 0, 8);
    add(-5, 1'b0, 1'b0);
    for (int x = 0; x < 12; x++) add(x, (x < 8), (x == 0));
    run_table();
    wait_done(8);
    check("t4_backpressure", 64'(bp_seen), 64'd1);
    rdy_mode = 0;

    // 5: falling at the most negative level, len 0 behaves as 1.
    do_arm(-32768, 1, SLOPE_FALL, 0, 0);
    add(-32768, 1'b0, 1'b0);
    add(-32767, 1'b0, 1'b0);
    add(-32766, 1'b0, 1'b0);
    add(-32768, 1'b1, 1'b1);
    add(-32768, 1'b0, 1'b0);
    run_table();
    wait_done(1);

    // 6: reset while FIRE holds an undrained sample, then re-arm.
    rdy_mode = 2;
    do_arm(0, 2, SLOPE_RISE, 0, 4);
    add(-5, 1'b0, 1'b0);
    add(0, 1'b1, 1'b1);
    run_table();
    @(negedge aclk);
    check("t6_fire_vld", 64'(m_tvalid), 64'd1);
    check("t6_fire_busy", 64'(busy), 64'd1);
    check("t6_fire_rdy", 64'(s_tready), 64'd0);
    rdy_mode = 0;
    do_reset();
    do_arm(0, 2, SLOPE_RISE, 0, 1);
    add(-5, 1'b0, 1'b0);
    add(7, 1'b1, 1'b1);
    add(8, 1'b0, 1'b0);
    run_table();
    wait_done(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
